// File: rtl/board_io_ctrl_if.sv
// Board I/O bundle between the pin-facing conditioning stage and the core side.
// The master drives the raw buttons, flags and classifier result; the slave
// (board_io_ctrl) returns the conditioned reset, pins, LEDs and held result.
interface board_io_if #(
  parameter int NUM_RST   = 2,
  parameter int NUM_FLAGS = 3,
  parameter int RESULT_W  = 4
);
  logic [NUM_RST-1:0]   ext_rst_n;
  logic                 sys_rst_n;
  logic [NUM_FLAGS-1:0] flag_in;
  logic [NUM_FLAGS-1:0] flag_pin;
  logic [NUM_FLAGS-1:0] flag_led;
  logic [RESULT_W-1:0]  result_in;
  logic                 result_valid_in;
  logic                 result_clear_in;
  logic [RESULT_W-1:0]  result_out;
  logic                 result_ready_pin;

  modport master (
    output ext_rst_n, flag_in, result_in, result_valid_in, result_clear_in,
    input  sys_rst_n, flag_pin, flag_led, result_out, result_ready_pin
  );

  modport slave (
    input  ext_rst_n, flag_in, result_in, result_valid_in, result_clear_in,
    output sys_rst_n, flag_pin, flag_led, result_out, result_ready_pin
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board-level I/O conditioning: debounced system reset from raw buttons,
// registered status pins with pulse-stretched LEDs, and a sticky result latch.
module board_io_ctrl #(
  parameter int NUM_RST      = 2,
  parameter int RST_MODE_AND = 0,
  parameter int DEBOUNCE_CYC = 16,
  parameter int NUM_FLAGS    = 3,
  parameter int STRETCH_CYC  = 50000,
  parameter int LED_INV      = 0,
  parameter int RESULT_W     = 4
) (
  input logic       clk,
  input logic       rst_n,
  board_io_if.slave bus
);

  localparam int DCW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SCW = (STRETCH_CYC > 0) ? $clog2(STRETCH_CYC + 1) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYC - 1);
  localparam logic [SCW-1:0] ST_LOAD  = SCW'(STRETCH_CYC);
  localparam logic           INV      = (LED_INV != 0);

  logic [NUM_RST-1:0]   sync1_q, sync2_q;
  logic                 filt_q, filt_d;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 sys_rst_q;
  logic                 cmb;
  logic [NUM_FLAGS-1:0] flag_pin_q;
  logic [SCW-1:0]       scnt_q [NUM_FLAGS];
  logic [NUM_FLAGS-1:0] led_on;
  logic [RESULT_W-1:0]  result_q;
  logic                 ready_q;

  // Combine synchronised buttons and compute the debounce next state.
  always_comb begin
    cmb    = (RST_MODE_AND != 0) ? (&sync2_q) : (|sync2_q);
    filt_d = filt_q;
    dcnt_d = '0;
    if (cmb != filt_q) begin
      if (dcnt_q == DEB_LAST) begin
        filt_d = cmb;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end
  end

  // Reset path: 2-flop synchronisers, debounce filter and registered reset out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= 1'b0;
      dcnt_q    <= '0;
      sys_rst_q <= 1'b0;
    end else begin
      sync1_q   <= bus.ext_rst_n;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      dcnt_q    <= dcnt_d;
      sys_rst_q <= filt_q;
    end
  end

  // Flag pins and stretch counters; held clear while the core is in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_pin_q <= '0;
      for (int i = 0; i < NUM_FLAGS; i++) scnt_q[i] <= '0;
    end else if (!sys_rst_q) begin
      flag_pin_q <= '0;
      for (int i = 0; i < NUM_FLAGS; i++) scnt_q[i] <= '0;
    end else begin
      flag_pin_q <= bus.flag_in;
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (STRETCH_CYC == 0) begin
          scnt_q[i] <= '0;
        end else if (bus.flag_in[i]) begin
          scnt_q[i] <= ST_LOAD;
        end else if (scnt_q[i] != '0) begin
          scnt_q[i] <= scnt_q[i] - SCW'(1);
        end
      end
    end
  end

  // LED drive: stretched activity, or a plain pin mirror when stretching is off.
  always_comb begin
    led_on = '0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      led_on[i] = ((STRETCH_CYC == 0) ? flag_pin_q[i] : (scnt_q[i] != '0)) ^ INV;
    end
  end

  // Sticky result latch; a valid strobe beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ready_q  <= 1'b0;
    end else if (!sys_rst_q) begin
      result_q <= '0;
      ready_q  <= 1'b0;
    end else if (bus.result_valid_in) begin
      result_q <= bus.result_in;
      ready_q  <= 1'b1;
    end else if (bus.result_clear_in) begin
      ready_q  <= 1'b0;
    end
  end

  assign bus.sys_rst_n        = sys_rst_q;
  assign bus.flag_pin         = flag_pin_q;
  assign bus.flag_led         = led_on;
  assign bus.result_out       = result_q;
  assign bus.result_ready_pin = ready_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: three parameter variants driven by shared stimulus
// and compared every cycle against a window/timestamp reference model.
module tb_board_io_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ext = 2'b11;
  logic [2:0] flg = 3'b000;
  logic [3:0] res_in = 4'h0;
  logic       vld = 1'b0;
  logic       clr = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  board_io_if #(.NUM_RST(2), .NUM_FLAGS(3), .RESULT_W(4)) if0 ();
  board_io_if #(.NUM_RST(2), .NUM_FLAGS(3), .RESULT_W(4)) if1 ();
  board_io_if #(.NUM_RST(2), .NUM_FLAGS(3), .RESULT_W(4)) if2 ();

  assign if0.ext_rst_n = ext;  assign if1.ext_rst_n = ext;  assign if2.ext_rst_n = ext;
  assign if0.flag_in = flg;    assign if1.flag_in = flg;    assign if2.flag_in = flg;
  assign if0.result_in = res_in; assign if1.result_in = res_in; assign if2.result_in = res_in;
  assign if0.result_valid_in = vld; assign if1.result_valid_in = vld; assign if2.result_valid_in = vld;
  assign if0.result_clear_in = clr; assign if1.result_clear_in = clr; assign if2.result_clear_in = clr;

  board_io_ctrl #(.NUM_RST(2), .RST_MODE_AND(0), .DEBOUNCE_CYC(DEB), .NUM_FLAGS(3),
                  .STRETCH_CYC(10), .LED_INV(0), .RESULT_W(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  board_io_ctrl #(.NUM_RST(2), .RST_MODE_AND(1), .DEBOUNCE_CYC(DEB), .NUM_FLAGS(3),
                  .STRETCH_CYC(10), .LED_INV(1), .RESULT_W(4))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  board_io_ctrl #(.NUM_RST(2), .RST_MODE_AND(0), .DEBOUNCE_CYC(DEB), .NUM_FLAGS(3),
                  .STRETCH_CYC(0), .LED_INV(1), .RESULT_W(4))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Reference model configuration per DUT.
  int MODE [3] = '{0, 1, 0};
  int INV  [3] = '{0, 1, 1};
  int ST   [3] = '{10, 10, 0};

  // Reference model state.
  logic [1:0] rh [$];
  bit         win [3][$];
  logic       filt_m [3];
  logic       sys_m [3];
  logic [2:0] pin_m [3];
  int         last_hi [3][3];
  logic [3:0] res_m [3];
  logic       rdy_m [3];
  int         k = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rh.delete();
    rh.push_back(2'b00);
    rh.push_back(2'b00);
    for (int d = 0; d < 3; d++) begin
      win[d].delete();
      filt_m[d] = 1'b0;
      sys_m[d]  = 1'b0;
      pin_m[d]  = 3'b000;
      res_m[d]  = 4'h0;
      rdy_m[d]  = 1'b0;
      for (int i = 0; i < 3; i++) last_hi[d][i] = -1000;
    end
  endtask

  // One clock edge of the reference: the combined button value that reaches
  // the filter is the raw input sampled two edges earlier; the filter flips
  // once the last DEB such values all disagree with it.
  task automatic model_step();
    logic [1:0] rd;
    k++;
    rd = rh[0];
    for (int d = 0; d < 3; d++) begin
      bit   c;
      bit   all;
      logic old_sys;
      logic old_filt;
      c = (MODE[d] != 0) ? (&rd) : (|rd);
      old_sys  = sys_m[d];
      old_filt = filt_m[d];
      win[d].push_back(c);
      if (win[d].size() > DEB) void'(win[d].pop_front());
      if (win[d].size() == DEB) begin
        all = 1'b1;
        for (int j = 0; j < DEB; j++) if (win[d][j] == old_filt) all = 1'b0;
        if (all) filt_m[d] = c;
      end
      sys_m[d] = old_filt;
      if (!old_sys) begin
        pin_m[d] = 3'b000;
        res_m[d] = 4'h0;
        rdy_m[d] = 1'b0;
        for (int i = 0; i < 3; i++) last_hi[d][i] = -1000;
      end else begin
        pin_m[d] = flg;
        for (int i = 0; i < 3; i++) if (flg[i]) last_hi[d][i] = k;
        if (vld) begin
          res_m[d] = res_in;
          rdy_m[d] = 1'b1;
        end else if (clr) begin
          rdy_m[d] = 1'b0;
        end
      end
    end
    void'(rh.pop_front());
    rh.push_back(ext);
  endtask

  task automatic cmp(input int d, input logic s, input logic [2:0] p, input logic [2:0] l,
                     input logic [3:0] r, input logic y);
    logic [2:0] el;
    for (int i = 0; i < 3; i++) begin
      if (ST[d] == 0) el[i] = pin_m[d][i] ^ (INV[d] != 0);
      else            el[i] = ((k - last_hi[d][i]) < ST[d]) ^ (INV[d] != 0);
    end
    check_eq($sformatf("d%0d_sys", d), 32'(s), 32'(sys_m[d]));
    check_eq($sformatf("d%0d_pin", d), 32'(p), 32'(pin_m[d]));
    check_eq($sformatf("d%0d_led", d), 32'(l), 32'(el));
    check_eq($sformatf("d%0d_res", d), 32'(r), 32'(res_m[d]));
    check_eq($sformatf("d%0d_rdy", d), 32'(y), 32'(rdy_m[d]));
  endtask

  task automatic cmp_all();
    cmp(0, if0.sys_rst_n, if0.flag_pin, if0.flag_led, if0.result_out, if0.result_ready_pin);
    cmp(1, if1.sys_rst_n, if1.flag_pin, if1.flag_led, if1.result_out, if1.result_ready_pin);
    cmp(2, if2.sys_rst_n, if2.flag_pin, if2.flag_led, if2.result_out, if2.result_ready_pin);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic check_async_reset();
    check_eq("ar_sys0", 32'(if0.sys_rst_n), 32'h0);
    check_eq("ar_sys1", 32'(if1.sys_rst_n), 32'h0);
    check_eq("ar_pin0", 32'(if0.flag_pin), 32'h0);
    check_eq("ar_led0", 32'(if0.flag_led), 32'h0);
    check_eq("ar_led1", 32'(if1.flag_led), 32'h7);
    check_eq("ar_led2", 32'(if2.flag_led), 32'h7);
    check_eq("ar_res0", 32'(if0.result_out), 32'h0);
    check_eq("ar_rdy0", 32'(if0.result_ready_pin), 32'h0);
    check_eq("ar_rdy1", 32'(if1.result_ready_pin), 32'h0);
  endtask

  initial begin
    int burst;
    logic [1:0] bval;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_async_reset();
    #1;
    rst_n = 1'b1;

    // Release: reset rises on the 7th edge after release (edge index 6).
    for (int n = 0; n < 8; n++) begin
      tick();
      if (n == 5) check_eq("rel_hold", 32'(if0.sys_rst_n), 32'h0);
      if (n == 6) check_eq("rel_rise", 32'(if0.sys_rst_n), 32'h1);
    end

    // Short glitch on one button, then a full press of both.
    ext = 2'b10; cycles(3);
    ext = 2'b11; cycles(8);
    ext = 2'b00; cycles(5);
    ext = 2'b11; cycles(12);
    // One button held: AND variant stays in reset, OR variants run.
    ext = 2'b10; cycles(10);
    check_eq("and_hold", 32'(if1.sys_rst_n), 32'h0);
    ext = 2'b11; cycles(10);

    // LED stretch: single pulse, then pulse and retrigger 5 cycles later.
    flg = 3'b010; tick(); flg = 3'b000; cycles(12);
    flg = 3'b010; tick(); flg = 3'b000; cycles(4);
    flg = 3'b010; tick(); flg = 3'b000; cycles(12);
    flg = 3'b101; cycles(3); flg = 3'b000; cycles(12);

    // Result latch: valid, valid+clear, clear alone.
    res_in = 4'h7; vld = 1'b1; tick(); vld = 1'b0;
    check_eq("res7", 32'(if0.result_out), 32'h7);
    check_eq("rdy7", 32'(if0.result_ready_pin), 32'h1);
    res_in = 4'h3; vld = 1'b1; clr = 1'b1; tick(); vld = 1'b0; clr = 1'b0;
    check_eq("res3", 32'(if0.result_out), 32'h3);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_rdy", 32'(if0.result_ready_pin), 32'h0);
    check_eq("clr_res", 32'(if0.result_out), 32'h3);

    // Core reset while ready and an LED stretch are active.
    res_in = 4'h9; vld = 1'b1; tick(); vld = 1'b0;
    flg = 3'b111; tick(); flg = 3'b000;
    ext = 2'b00; cycles(10);
    check_eq("mid_rdy", 32'(if0.result_ready_pin), 32'h0);
    check_eq("mid_led", 32'(if0.flag_led), 32'h0);
    ext = 2'b11; cycles(12);

    // Randomised traffic with occasional button bursts.
    burst = 0;
    bval = 2'b11;
    for (int n = 0; n < 600; n++) begin
      if (burst == 0 && ($urandom % 25) == 0) begin
        burst = $urandom_range(1, 9);
        bval = 2'($urandom);
      end
      if (burst > 0) begin
        ext = bval;
        burst--;
      end else begin
        ext = 2'b11;
      end
      for (int i = 0; i < 3; i++) flg[i] = (($urandom % 7) == 0);
      res_in = 4'($urandom);
      vld = (($urandom % 6) == 0);
      clr = (($urandom % 6) == 0);
      tick();
    end
    flg = 3'b000; vld = 1'b0; clr = 1'b0;
    ext = 2'b11; cycles(12);

    // Asynchronous reset in the middle of a debounce run.
    flg = 3'b011; res_in = 4'h5; vld = 1'b1; tick(); vld = 1'b0;
    ext = 2'b00; cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_async_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    flg = 3'b000;
    ext = 2'b11;
    rst_n = 1'b1;
    cycles(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-level I/O conditioning stage between the FPGA pins and `system_controller`. It merges several raw board reset buttons into one debounced system reset whose release is synchronous to `clk`, and registers the core status flags onto pins. Each flag also drives a pulse-stretched, optionally inverted LED so that single-cycle events stay visible. It captures the classifier result with a sticky ready indication. It replaces the hard-wired two-button OR and the direct flag-to-pin/LED wiring of the current top level.

## Interface
- `NUM_RST`, 2: number of raw board reset inputs.
- `RST_MODE_AND`, 0: 0 = system runs if any button input is high (legacy OR); 1 = all inputs must be high.
- `DEBOUNCE_CYC`, 16: consecutive stable cycles required before the filtered reset state changes; must be ≥1.
- `NUM_FLAGS`, 3: number of status flag channels.
- `STRETCH_CYC`, 50000: LED hold time in cycles; 0 = LED mirrors pin.
- `LED_INV`, 0: 1 = LEDs active-low.
- `RESULT_W`, 4: result width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low power-on reset for this block.
- `ext_rst_n` in NUM_RST: raw asynchronous board reset buttons, active-low.
- `sys_rst_n` out 1: conditioned active-low reset to the core.
- `flag_in` in NUM_FLAGS: core status flags, `clk` domain.
- `flag_pin` out NUM_FLAGS: registered flags to the header pins.
- `flag_led` out NUM_FLAGS: stretched flags to the LEDs.
- `result_in` in RESULT_W: classifier result.
- `result_valid_in` in 1: single-cycle strobe that `result_in` is valid.
- `result_clear_in` in 1: single-cycle strobe that drops the ready indication (new image started).
- `result_out` out RESULT_W: held result.
- `result_ready_pin` out 1: sticky result-ready indication.

## Operation
- Reset path:
  - Each `ext_rst_n` bit passes through a 2-flop synchroniser.
  - The synchronised bits are combined by OR (mode 0) or AND (mode 1) into `cmb`; high means run.
  - Counter `dcnt` increments while `cmb != filt` and clears to 0 whenever `cmb == filt`.
  - When `dcnt == DEBOUNCE_CYC-1` and `cmb != filt`, `filt <= cmb` and `dcnt <= 0`.
  - `sys_rst_n <= filt` (registered); both assertion and deassertion are synchronous.
  - A glitch shorter than DEBOUNCE_CYC cycles never reaches `sys_rst_n`.
- Flags, per channel i:
  - `flag_pin[i] <= flag_in[i]`.
  - When `flag_in[i]` is sampled high, stretch counter `scnt[i] <= STRETCH_CYC`; otherwise it decrements if nonzero.
  - `flag_led[i] = (scnt[i] != 0) ^ LED_INV`.
  - If STRETCH_CYC == 0, `flag_led[i] = flag_pin[i] ^ LED_INV`.
  - Counter width is $clog2(STRETCH_CYC+1).
- Result:
  - On `result_valid_in`: `result_out <= result_in`, `result_ready_pin <= 1`.
  - On `result_clear_in` alone: `result_ready_pin <= 0`; `result_out` is held.
  - If valid and clear arrive in the same cycle, valid wins.
- While `sys_rst_n == 0`, the flag registers, stretch counters, `result_out` and `result_ready_pin` are synchronously cleared. The reset-path logic keeps running.

## Timing
- `rst_n` low, asynchronously: synchronisers, `filt`, `dcnt` = 0; `sys_rst_n` = 0; `flag_pin` = 0; `flag_led` = {NUM_FLAGS{LED_INV}}; `result_out` = 0; `result_ready_pin` = 0.
- After `rst_n` rises with buttons released: `sys_rst_n` rises DEBOUNCE_CYC+2 cycles after the first edge that samples `cmb`-high at the synchroniser input.
- Button press or release to `sys_rst_n` change: DEBOUNCE_CYC+2 cycles, counted from the sampling edge.
- Input that bounces back before a full run restarts the count: `dcnt` returns to 0.
- `flag_pin` latency is 1 cycle. `flag_led` asserts on the same edge as `flag_pin`.
- A 1-cycle flag pulse gives a `flag_led` high time of STRETCH_CYC cycles. A level held L cycles gives L+STRETCH_CYC-1 cycles. Re-triggering during a stretch reloads the counter.
- `result_out` and `result_ready_pin` have 1-cycle latency from their strobes.

## Test plan
- Reset release, defaults with DEBOUNCE_CYC=4: `rst_n` 0→1 with `ext_rst_n`=2'b11 → `sys_rst_n` rises exactly 6 cycles after the first sampling edge; all other outputs stay at their reset values until then.
- Debounce: with DEBOUNCE_CYC=4, drop `ext_rst_n[0]` for 3 cycles → no change on `sys_rst_n`. Drive `ext_rst_n`=2'b00 for 5 cycles → `sys_rst_n` falls 6 cycles after the first low sample. Also verify mode 1: `ext_rst_n`=2'b10 holds the core in reset.
- LED stretch with STRETCH_CYC=10: 1-cycle pulse on `flag_in[1]` → `flag_pin[1]` high for 1 cycle and `flag_led[1]` high for 10 cycles. A second pulse at cycle 5 → LED stays high until cycle 15. With LED_INV=1, the LED waveform is inverted.
- Result: `result_valid_in` with `result_in`=4'h7 → `result_out`=7 and `result_ready_pin`=1 on the next cycle. Valid+clear together with 4'h3 → ready stays 1 and `result_out`=3. Clear alone → ready 0 and `result_out` stays 3.
- Reset mid-operation: a core reset while ready=1 and an LED stretch is active → on the `sys_rst_n` low cycle, ready, result, pins and LEDs clear. Async `rst_n` low mid-debounce → everything resets immediately.
